// File: rtl/fnd_share_arbiter.sv
// Round-robin owner selection for the shared 4-digit FND display.
// Enforces a minimum on-screen time (OWN + LINGER) and a maximum hold while contested.
module fnd_share_arbiter #(
    parameter int MIN_HOLD = 16,
    parameter int MAX_HOLD = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  req,
    input  logic [15:0] value0,
    input  logic [15:0] value1,
    input  logic [15:0] value2,
    output logic [2:0]  grant,
    output logic [15:0] fnd_value,
    output logic        busy
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] MIN_LAST = HW'(MIN_HOLD - 1);
    localparam logic [HW-1:0] MAX_LAST = HW'(MAX_HOLD - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_OWN    = 2'd1;
    localparam logic [1:0] S_LINGER = 2'd2;

    logic [1:0]    r_state;
    logic [2:0]    r_grant;
    logic [15:0]   r_fnd;
    logic [HW-1:0] r_hold;
    logic [1:0]    r_last;
    logic          r_busy;

    logic [1:0]    w_nxt_state;
    logic [2:0]    w_nxt_grant;
    logic [15:0]   w_nxt_fnd;
    logic [HW-1:0] w_nxt_hold;
    logic [1:0]    w_nxt_last;
    logic [2:0]    w_win;
    logic          w_take;
    logic          w_owner_req;
    logic [2:0]    w_others;
    logic [HW-1:0] w_hold_inc;

    // Rank order is last+1, last+2, last, so the previous owner is always lowest.
    function automatic logic [2:0] f_rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [2:0] pick;
        pick = 3'b000;
        case (last)
            2'd0: begin
                if (r[1])      pick = 3'b010;
                else if (r[2]) pick = 3'b100;
                else if (r[0]) pick = 3'b001;
            end
            2'd1: begin
                if (r[2])      pick = 3'b100;
                else if (r[0]) pick = 3'b001;
                else if (r[1]) pick = 3'b010;
            end
            default: begin
                if (r[0])      pick = 3'b001;
                else if (r[1]) pick = 3'b010;
                else if (r[2]) pick = 3'b100;
            end
        endcase
        return pick;
    endfunction

    function automatic logic [1:0] f_idx(input logic [2:0] onehot);
        logic [1:0] idx;
        case (onehot)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [15:0] f_value(input logic [2:0] onehot, input logic [15:0] v0,
                                            input logic [15:0] v1, input logic [15:0] v2);
        logic [15:0] v;
        case (onehot)
            3'b001:  v = v0;
            3'b010:  v = v1;
            3'b100:  v = v2;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    always_comb begin
        w_owner_req = |(req & r_grant);
        w_others    = req & ~r_grant;
        w_hold_inc  = (r_hold == MAX_LAST) ? r_hold : r_hold + 1'b1;

        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_fnd   = r_fnd;
        w_nxt_hold  = r_hold;
        w_nxt_last  = r_last;
        w_win       = 3'b000;
        w_take      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_nxt_grant = 3'b000;
                if (|req) begin
                    w_win  = f_rr_pick(req, r_last);
                    w_take = 1'b1;
                end
            end
            S_OWN: begin
                w_nxt_hold = w_hold_inc;
                w_nxt_fnd  = f_value(r_grant, value0, value1, value2);
                if (!w_owner_req) begin
                    // Release takes priority over a coincident preempt.
                    if (r_hold < MIN_LAST) begin
                        w_nxt_state = S_LINGER;
                        w_nxt_grant = 3'b000;
                        w_nxt_fnd   = r_fnd;
                    end else if (|w_others) begin
                        w_win  = f_rr_pick(w_others, r_last);
                        w_take = 1'b1;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_grant = 3'b000;
                        w_nxt_fnd   = r_fnd;
                    end
                end else if ((|w_others) && (r_hold == MAX_LAST)) begin
                    w_win  = f_rr_pick(w_others, r_last);
                    w_take = 1'b1;
                end
            end
            S_LINGER: begin
                w_nxt_hold  = w_hold_inc;
                w_nxt_grant = 3'b000;
                if (r_hold == MIN_LAST) begin
                    if (|req) begin
                        w_win  = f_rr_pick(req, r_last);
                        w_take = 1'b1;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_grant = 3'b000;
            end
        endcase

        if (w_take) begin
            w_nxt_state = S_OWN;
            w_nxt_grant = w_win;
            w_nxt_fnd   = f_value(w_win, value0, value1, value2);
            w_nxt_hold  = '0;
            w_nxt_last  = f_idx(w_win);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_grant <= 3'b000;
            r_fnd   <= 16'h0000;
            r_hold  <= '0;
            r_last  <= 2'd2;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_fnd   <= w_nxt_fnd;
            r_hold  <= w_nxt_hold;
            r_last  <= w_nxt_last;
            r_busy  <= (w_nxt_state != S_IDLE);
        end
    end

    assign grant     = r_grant;
    assign fnd_value = r_fnd;
    assign busy      = r_busy;

endmodule

// File: tb/tb_fnd_share_arbiter.sv
// Directed bench for fnd_share_arbiter with MIN_HOLD=4, MAX_HOLD=8.
module tb_fnd_share_arbiter;

    logic        clk;
    logic        reset_n;
    logic [2:0]  req;
    logic [15:0] value0;
    logic [15:0] value1;
    logic [15:0] value2;
    logic [2:0]  grant;
    logic [15:0] fnd_value;
    logic        busy;

    int n_chk;
    int n_fail;

    fnd_share_arbiter #(.MIN_HOLD(4), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .value0    (value0),
        .value1    (value1),
        .value2    (value2),
        .grant     (grant),
        .fnd_value (fnd_value),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 3'b000;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        req     = 3'b000;
        value0  = 16'h0000;
        value1  = 16'h0000;
        value2  = 16'h0000;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_fnd", 32'(fnd_value), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'h0);

        // single requester, grant latency and live value tracking
        req    = 3'b001;
        value0 = 16'h1234;
        tick();
        chk("s1_grant", 32'(grant), 32'h1);
        chk("s1_busy", 32'(busy), 32'h1);
        chk("s1_fnd", 32'(fnd_value), 32'h1234);
        value0 = 16'hABCD;
        tick();
        chk("s1_track", 32'(fnd_value), 32'hABCD);
        req = 3'b000;
        tick();
        chk("s1_lng_grant", 32'(grant), 32'h0);
        chk("s1_lng_busy", 32'(busy), 32'h1);
        tick();
        chk("s1_lng2_busy", 32'(busy), 32'h1);
        tick();
        chk("s1_idle_busy", 32'(busy), 32'h0);
        chk("s1_idle_fnd", 32'(fnd_value), 32'hABCD);

        // all three requesting: rotation every MAX_HOLD cycles
        do_reset();
        value0 = 16'h1111;
        value1 = 16'h2222;
        value2 = 16'h3333;
        req    = 3'b111;
        tick();
        chk("s2_first", 32'(grant), 32'h1);
        begin
            logic [2:0]  seq_g [4];
            logic [15:0] seq_v [4];
            seq_g = '{3'b001, 3'b010, 3'b100, 3'b001};
            seq_v = '{16'h1111, 16'h2222, 16'h3333, 16'h1111};
            for (int s = 1; s < 4; s++) begin
                for (int k = 1; k < 8; k++) begin
                    tick();
                    chk("s2_hold", 32'(grant), 32'(seq_g[s-1]));
                end
                tick();
                chk("s2_switch", 32'(grant), 32'(seq_g[s]));
                chk("s2_fnd", 32'(fnd_value), 32'(seq_v[s]));
            end
        end

        // early release lingers until MIN_HOLD cycles total
        do_reset();
        value1 = 16'h5A5A;
        req    = 3'b010;
        tick();
        chk("s3_grant", 32'(grant), 32'h2);
        tick();
        req    = 3'b000;
        tick();
        value1 = 16'hFFFF;
        chk("s3_lng_grant", 32'(grant), 32'h0);
        chk("s3_lng_busy", 32'(busy), 32'h1);
        tick();
        chk("s3_lng_fnd", 32'(fnd_value), 32'h5A5A);
        chk("s3_lng_busy2", 32'(busy), 32'h1);
        tick();
        chk("s3_idle_busy", 32'(busy), 32'h0);
        chk("s3_idle_grant", 32'(grant), 32'h0);

        // release after long hold with a rival pending: direct one-hot switch
        do_reset();
        value0 = 16'h00A0;
        value2 = 16'h0C0C;
        req    = 3'b001;
        tick();
        for (int k = 0; k < 9; k++) tick();
        chk("s4_owner", 32'(grant), 32'h1);
        req = 3'b100;
        tick();
        chk("s4_switch", 32'(grant), 32'h4);
        chk("s4_fnd", 32'(fnd_value), 32'h0C0C);
        chk("s4_busy", 32'(busy), 32'h1);

        // lone owner is never preempted
        do_reset();
        req = 3'b010;
        tick();
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("s5_hold", 32'(grant), 32'h2);
        end

        // async reset mid-LINGER
        do_reset();
        value0 = 16'h4444;
        req    = 3'b001;
        tick();
        tick();
        req = 3'b000;
        tick();
        chk("s6_lng_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("s6_rst_grant", 32'(grant), 32'h0);
        chk("s6_rst_fnd", 32'(fnd_value), 32'h0);
        chk("s6_rst_busy", 32'(busy), 32'h0);
        #1;
        reset_n = 1'b1;

        // async reset mid-OWN, then pointer must be back at 2
        value1 = 16'h7777;
        req    = 3'b010;
        tick();
        tick();
        chk("s6_own", 32'(grant), 32'h2);
        reset_n = 1'b0;
        req     = 3'b000;
        #1;
        chk("s6_rst2_grant", 32'(grant), 32'h0);
        chk("s6_rst2_fnd", 32'(fnd_value), 32'h0);
        chk("s6_rst2_busy", 32'(busy), 32'h0);
        #1;
        reset_n = 1'b1;
        req     = 3'b110;
        tick();
        chk("s6_ptr", 32'(grant), 32'h2);
        chk("s6_ptr_fnd", 32'(fnd_value), 32'h7777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fnd_share_arbiter.md
# fnd_share_arbiter

- Arbitrates three requesters that share the single 4-digit FND display.
- Selects one owner with round-robin fairness and presents that owner's 16-bit value on `fnd_value`. This output feeds the FND scan/decoder driver directly.
- Enforces a minimum on-screen time so values stay readable, and a maximum hold time so no owner starves the others.

## Interface
- `MIN_HOLD`, 16: minimum cycles a granted value stays on the display (≥1).
- `MAX_HOLD`, 1024: cycles after which a contested owner is preempted (> `MIN_HOLD`).
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  3  request per requester; level, held while display wanted.
- `value0`  in  16  requester 0 display value (4 hex digits).
- `value1`  in  16  requester 1 display value.
- `value2`  in  16  requester 2 display value.
- `grant`  out  3  one-hot owner, or 0 when no owner.
- `fnd_value`  out  16  value to FND driver.
- `busy`  out  1  display in use (state OWN or LINGER).

## Operation
- Reset (async, `reset_n`=0): `grant`=0, `fnd_value`=16'h0000, `busy`=0, state IDLE, `hold_cnt`=0, round-robin pointer `last`=2 (requester 0 ranks first).
- Round-robin order: `last`+1, `last`+2, `last` (mod 3). `last` updates to each new owner when it is granted.
- `hold_cnt` width is clog2(`MAX_HOLD`+1). It saturates at `MAX_HOLD`-1 and clears on every new grant.
- "Others pending" means any `req` bit other than the current owner's.
- IDLE:
  - No request: `grant`=0, `busy`=0, `fnd_value` holds its last value.
  - Any `req` bit set: select winner → OWN. At that edge set `grant` to the winner, `fnd_value` to value[winner], `hold_cnt` to 0.
- OWN:
  - `fnd_value` is loaded with value[owner] every cycle (live tracking).
  - `hold_cnt` increments.
  - Owner's `req`=0 with `hold_cnt` < `MIN_HOLD`-1 → LINGER. `grant` drops to 0 and `fnd_value` freezes.
  - Owner's `req`=0 with `hold_cnt` ≥ `MIN_HOLD`-1 → re-arbitrate. If others are pending, go to OWN with the new owner. Otherwise go to IDLE.
  - Owner's `req`=1, others pending, `hold_cnt`==`MAX_HOLD`-1 → preempt: new owner by round-robin, `hold_cnt`=0.
  - Owner's `req`=1, no others pending → remain in OWN indefinitely.
- LINGER:
  - `grant`=0, `busy`=1, `fnd_value` frozen, `hold_cnt` keeps incrementing.
  - At `hold_cnt`==`MIN_HOLD`-1 → arbitrate among current `req`, with the previous owner included at lowest rank. Any pending → OWN; else → IDLE.
- Simultaneous events:
  - Owner release and preempt in the same cycle: the release path wins.
  - New requests arriving mid-hold wait for release, preempt, or linger end. No other preemption exists.
- `MIN_HOLD`=1: LINGER is unreachable.
- Reset mid-operation: immediate return to reset values regardless of state.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Grant latency: `req` sampled high at edge N while IDLE → `grant` and `fnd_value` valid after edge N.
- Value tracking in OWN: a change of value[owner] appears on `fnd_value` one cycle later.
- Release: `req` low sampled at edge N → `grant` changes after edge N, going to 0 or to the new owner.
- Ownership switch: `grant` goes directly from one one-hot code to another in one edge. There is no zero gap and no cycle with two bits set.
- Minimum display time of any granted value is `MIN_HOLD` cycles, counting OWN plus LINGER.
- Maximum wait for a pending requester is 2×`MAX_HOLD` + 2 cycles (two rivals ahead).

## Test plan
Run all scenarios with `MIN_HOLD`=4, `MAX_HOLD`=8.
- Reset, then `req`=3'b001, `value0`=16'h1234:
  - `grant`=001, `busy`=1 and `fnd_value`=1234 one edge after `req` is sampled.
  - Changing `value0` to 16'hABCD shows ABCD one cycle later.
- `req`=3'b111 from IDLE after reset:
  - `grant`=001 first.
  - Holding all requests, the grant sequence is 001→010→100→001, each lasting exactly 8 cycles.
- Requester 1 granted, drops `req` after 2 cycles, none pending:
  - `grant`=0, `busy`=1, `fnd_value` frozen until 4 cycles total.
  - Then IDLE with `busy`=0.
- Requester 0 owns for 10 cycles, then releases while `req[2]`=1:
  - `grant` switches 001→100 on one edge.
  - `fnd_value`=`value2` on the same edge.
- Single owner `req`=3'b010 held 50 cycles with no others: `grant` stays 010 with no preemption.
- Assert `reset_n`=0 mid-LINGER and mid-OWN:
  - All outputs clear asynchronously.
  - After release, `req`=3'b110 grants 010 first (pointer reset).
